// File: rtl/matmul_c_drain_writer.sv
// C-output drain writer: buffers two non-stallable row streams and writes them to C memory.
// Optional build macro C_DRAIN_ADDR_CHECK_EN enables the per-lane address sequence checker.
module matmul_c_drain_writer #(
  parameter int unsigned DWIDTH            = 8,
  parameter int unsigned BB_MAT_MUL_SIZE   = 16,
  parameter int unsigned AWIDTH            = 10,
  parameter int unsigned ADDR_STRIDE_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH        = 4,
  parameter int unsigned ROWS_PER_LANE     = 16
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              start_mat_mul,
  input  logic [ADDR_STRIDE_WIDTH-1:0]      address_stride_c,
  input  logic [BB_MAT_MUL_SIZE*DWIDTH-1:0] c_data_0,
  input  logic [AWIDTH-1:0]                 c_addr_0,
  input  logic                              c_data_0_available,
  input  logic [BB_MAT_MUL_SIZE*DWIDTH-1:0] c_data_1,
  input  logic [AWIDTH-1:0]                 c_addr_1,
  input  logic                              c_data_1_available,
  output logic [BB_MAT_MUL_SIZE*DWIDTH-1:0] c_wr_data,
  output logic [AWIDTH-1:0]                 c_wr_addr,
  output logic                              c_wr_en,
  input  logic                              c_wr_ready,
  output logic                              done_drain,
  output logic                              overflow,
  output logic                              addr_error
);

  localparam int unsigned LW    = BB_MAT_MUL_SIZE * DWIDTH;
  localparam int unsigned EW    = AWIDTH + LW;
  localparam int unsigned PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned TOTAL = 2 * ROWS_PER_LANE;
  localparam int unsigned CW    = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic            run_c;
  logic            start_op_c;
  logic            done_next_c;
  logic            drained_c;

  logic [EW-1:0]   mem_q     [2][FIFO_DEPTH];
  logic [PW:0]     wr_ptr_q  [2];
  logic [PW:0]     rd_ptr_q  [2];
  logic [EW-1:0]   lane_in_c [2];
  logic [1:0]      empty_c;
  logic [1:0]      full_c;
  logic [1:0]      strobe_c;
  logic [1:0]      push_c;
  logic [1:0]      pop_c;
  logic [1:0]      drop_c;

  logic            last_grant_q;
  logic            grant_c;
  logic            accept_c;
  logic            load_c;
  logic [EW-1:0]   head_c;

  logic [CW-1:0]   cnt_q;

  assign lane_in_c[0] = {c_addr_0, c_data_0};
  assign lane_in_c[1] = {c_addr_1, c_data_1};

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_mat_mul) state_d = S_DRAIN;
      S_DRAIN: begin
        if (!start_mat_mul)  state_d = S_IDLE;
        else if (drained_c)  state_d = S_DONE;
      end
      S_DONE:  if (!start_mat_mul) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM output decode; datapath only moves while the operation stays in DRAIN
  always_comb begin
    run_c       = 1'b0;
    start_op_c  = 1'b0;
    done_next_c = 1'b0;
    case (state_q)
      S_IDLE:  start_op_c = (state_d == S_DRAIN);
      S_DRAIN: run_c      = (state_d == S_DRAIN);
      default: ;
    endcase
    done_next_c = (state_d == S_DONE);
  end

  assign drained_c = (cnt_q == CW'(TOTAL)) && (&empty_c) && !c_wr_en;

  // FIFO status
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      empty_c[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      full_c[i]  = (wr_ptr_q[i] == {~rd_ptr_q[i][PW], rd_ptr_q[i][PW-1:0]});
    end
  end

  // Round-robin grant, output-register load and push/drop decisions
  always_comb begin
    accept_c = c_wr_en & c_wr_ready;
    load_c   = run_c & (~c_wr_en | accept_c) & ~(&empty_c);
    if (!empty_c[0] && !empty_c[1]) grant_c = ~last_grant_q;
    else                            grant_c = empty_c[0];
    pop_c = 2'b00;
    if (load_c) pop_c[grant_c] = 1'b1;
    strobe_c = {c_data_1_available, c_data_0_available} & {2{run_c}};
    push_c   = strobe_c & (~full_c | pop_c);
    drop_c   = strobe_c & full_c & ~pop_c;
    head_c   = mem_q[grant_c][rd_ptr_q[grant_c][PW-1:0]];
  end

  // Lane FIFO storage
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push_c[i]) mem_q[i][wr_ptr_q[i][PW-1:0]] <= lane_in_c[i];
    end
  end

  // Lane FIFO pointers; flushed whenever the operation is not running
  always_ff @(posedge clk) begin
    if (!resetn || !run_c) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push_c[i]) wr_ptr_q[i] <= wr_ptr_q[i] + (PW+1)'(1);
        if (pop_c[i])  rd_ptr_q[i] <= rd_ptr_q[i] + (PW+1)'(1);
      end
    end
  end

  // Output register; holds its word until the memory accepts it
  always_ff @(posedge clk) begin
    if (!resetn) begin
      c_wr_en      <= 1'b0;
      c_wr_data    <= '0;
      c_wr_addr    <= '0;
      last_grant_q <= 1'b1;
    end else if (!run_c) begin
      c_wr_en <= 1'b0;
    end else if (load_c) begin
      c_wr_en                <= 1'b1;
      {c_wr_addr, c_wr_data} <= head_c;
      last_grant_q           <= grant_c;
    end else if (accept_c) begin
      c_wr_en <= 1'b0;
    end
  end

  // Write counter, overflow flag and drain-done flag
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q      <= '0;
      overflow   <= 1'b0;
      done_drain <= 1'b0;
    end else begin
      done_drain <= done_next_c;
      if (start_op_c) begin
        cnt_q    <= '0;
        overflow <= 1'b0;
      end else if (run_c) begin
        if (accept_c && (cnt_q != CW'(TOTAL))) cnt_q <= cnt_q + CW'(1);
        if (|drop_c) overflow <= 1'b1;
      end
    end
  end

`ifdef C_DRAIN_ADDR_CHECK_EN
  logic [1:0]        seen_q;
  logic [AWIDTH-1:0] prev_addr_q [2];
  logic [AWIDTH-1:0] lane_addr_c [2];
  logic [AWIDTH-1:0] expect_c    [2];
  logic [1:0]        addr_bad_c;

  // Each strobe after the first in a lane must follow the previous one by the stride
  always_comb begin
    lane_addr_c[0] = c_addr_0;
    lane_addr_c[1] = c_addr_1;
    for (int i = 0; i < 2; i++) begin
      expect_c[i]   = prev_addr_q[i] + AWIDTH'(address_stride_c);
      addr_bad_c[i] = strobe_c[i] & seen_q[i] & (lane_addr_c[i] != expect_c[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      seen_q     <= 2'b00;
      addr_error <= 1'b0;
      for (int i = 0; i < 2; i++) prev_addr_q[i] <= '0;
    end else if (start_op_c) begin
      seen_q     <= 2'b00;
      addr_error <= 1'b0;
    end else if (run_c) begin
      for (int i = 0; i < 2; i++) begin
        if (strobe_c[i]) begin
          seen_q[i]      <= 1'b1;
          prev_addr_q[i] <= lane_addr_c[i];
        end
      end
      if (|addr_bad_c) addr_error <= 1'b1;
    end
  end
`else
  logic unused_stride_c;
  assign unused_stride_c = ^address_stride_c;
  assign addr_error      = 1'b0;
`endif

endmodule

// File: tb/tb_matmul_c_drain_writer.sv
// Randomized self-checking bench for matmul_c_drain_writer against a queue-based reference model.
module tb_matmul_c_drain_writer;

  localparam int unsigned AW    = 10;
  localparam int unsigned SW    = 16;
  localparam int unsigned LW    = 128;
  localparam int unsigned EW    = AW + LW;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TOTAL = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start_mat_mul;
  logic [SW-1:0] address_stride_c;
  logic [LW-1:0] c_data_0, c_data_1;
  logic [AW-1:0] c_addr_0, c_addr_1;
  logic          c_data_0_available, c_data_1_available;
  logic [LW-1:0] c_wr_data;
  logic [AW-1:0] c_wr_addr;
  logic          c_wr_en, c_wr_ready;
  logic          done_drain, overflow, addr_error;

  matmul_c_drain_writer dut (
    .clk                (clk),
    .resetn             (resetn),
    .start_mat_mul      (start_mat_mul),
    .address_stride_c   (address_stride_c),
    .c_data_0           (c_data_0),
    .c_addr_0           (c_addr_0),
    .c_data_0_available (c_data_0_available),
    .c_data_1           (c_data_1),
    .c_addr_1           (c_addr_1),
    .c_data_1_available (c_data_1_available),
    .c_wr_data          (c_wr_data),
    .c_wr_addr          (c_wr_addr),
    .c_wr_en            (c_wr_en),
    .c_wr_ready         (c_wr_ready),
    .done_drain         (done_drain),
    .overflow           (overflow),
    .addr_error         (addr_error)
  );

  always #5 clk = ~clk;

`ifdef C_DRAIN_ADDR_CHECK_EN
  bit chk_en = 1'b1;
`else
  bit chk_en = 1'b0;
`endif

  // Reference model: operation phase, per-lane row queues and a one-word output slot
  int            m_st;
  int            m_cnt;
  int            m_last;
  bit            m_ovf, m_aerr, m_sv;
  bit            m_seen0, m_seen1;
  logic [AW-1:0] m_prev0, m_prev1;
  logic [EW-1:0] m_word;
  logic [EW-1:0] q0[$];
  logic [EW-1:0] q1[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_writes = 0;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [LW-1:0] rand_data();
    logic [LW-1:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_addr(input int lane, input logic [AW-1:0] a);
    logic [AW-1:0] nx;
    if (lane == 0) begin
      nx = m_prev0 + AW'(address_stride_c);
      if (chk_en && m_seen0 && a != nx) m_aerr = 1'b1;
      m_seen0 = 1'b1; m_prev0 = a;
    end else begin
      nx = m_prev1 + AW'(address_stride_c);
      if (chk_en && m_seen1 && a != nx) m_aerr = 1'b1;
      m_seen1 = 1'b1; m_prev1 = a;
    end
  endtask

  task automatic model_run();
    logic [EW-1:0] v;
    int p;
    bit acc;
    v   = '0;
    acc = m_sv && c_wr_ready;
    p   = -1;
    if (!m_sv || acc) begin
      if (q0.size() > 0 && q1.size() > 0) p = (m_last == 0) ? 1 : 0;
      else if (q0.size() > 0)             p = 0;
      else if (q1.size() > 0)             p = 1;
    end
    if (p == 0) v = q0.pop_front();
    if (p == 1) v = q1.pop_front();
    if (c_data_0_available) begin
      model_addr(0, c_addr_0);
      if (q0.size() < int'(DEPTH)) q0.push_back({c_addr_0, c_data_0});
      else m_ovf = 1'b1;
    end
    if (c_data_1_available) begin
      model_addr(1, c_addr_1);
      if (q1.size() < int'(DEPTH)) q1.push_back({c_addr_1, c_data_1});
      else m_ovf = 1'b1;
    end
    if (acc && m_cnt < int'(TOTAL)) m_cnt++;
    if (p >= 0) begin
      m_sv = 1'b1; m_word = v; m_last = p;
    end else if (acc) begin
      m_sv = 1'b0;
    end
  endtask

  task automatic model_step();
    if (!resetn) begin
      m_st = 0; q0.delete(); q1.delete(); m_sv = 1'b0; m_cnt = 0;
      m_ovf = 1'b0; m_aerr = 1'b0; m_last = 1; m_seen0 = 1'b0; m_seen1 = 1'b0;
    end else begin
      case (m_st)
        0: if (start_mat_mul) begin
          m_st = 1; m_cnt = 0; m_ovf = 1'b0; m_aerr = 1'b0; m_seen0 = 1'b0; m_seen1 = 1'b0;
        end
        1: begin
          if (!start_mat_mul) begin
            m_st = 0; q0.delete(); q1.delete(); m_sv = 1'b0;
          end else if (m_cnt == int'(TOTAL) && q0.size() == 0 && q1.size() == 0 && !m_sv) begin
            m_st = 2;
          end else begin
            model_run();
          end
        end
        default: if (!start_mat_mul) m_st = 0;
      endcase
    end
  endtask

  // One clock: advance the model with the inputs the DUT samples, then compare after the edge
  task automatic cycle();
    if (c_wr_en === 1'b1 && c_wr_ready && resetn) n_writes++;
    @(posedge clk);
    model_step();
    #1;
    check("wr_en", LW'(c_wr_en), LW'(m_sv));
    if (m_sv) begin
      check("wr_data", c_wr_data, m_word[LW-1:0]);
      check("wr_addr", LW'(c_wr_addr), LW'(m_word[EW-1:LW]));
    end
    check("overflow", LW'(overflow), LW'(m_ovf));
    check("done_drain", LW'(done_drain), LW'(m_st == 2));
    check("addr_error", LW'(addr_error), LW'(m_aerr));
  endtask

  task automatic drive(input bit v0, input int a0, input bit v1, input int a1);
    c_data_0_available = v0; c_addr_0 = AW'(a0); c_data_0 = rand_data();
    c_data_1_available = v1; c_addr_1 = AW'(a1); c_data_1 = rand_data();
    cycle();
    c_data_0_available = 1'b0;
    c_data_1_available = 1'b0;
  endtask

  task automatic restart();
    start_mat_mul = 1'b0;
    cycle();
    start_mat_mul = 1'b1;
    cycle();
  endtask

  initial begin
    int la0, la1, stride;
    resetn = 1'b0; start_mat_mul = 1'b0; address_stride_c = SW'(1);
    c_data_0 = '0; c_data_1 = '0; c_addr_0 = '0; c_addr_1 = '0;
    c_data_0_available = 1'b0; c_data_1_available = 1'b0; c_wr_ready = 1'b0;
    repeat (3) cycle();
    check("rst_wr_en", LW'(c_wr_en), '0);
    check("rst_wr_data", c_wr_data, '0);
    check("rst_wr_addr", LW'(c_wr_addr), '0);
    check("rst_done", LW'(done_drain), '0);
    check("rst_overflow", LW'(overflow), '0);
    check("rst_addr_error", LW'(addr_error), '0);
    resetn = 1'b1;
    cycle();

    // Basic drain: both lanes strobe together, alternate grants starting at lane 0
    start_mat_mul = 1'b1; c_wr_ready = 1'b1;
    cycle();
    n_writes = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, i, 1'b1, 16 + i);
      drive(1'b0, 0, 1'b0, 0);
    end
    repeat (6) cycle();
    check("basic_writes", LW'(n_writes), LW'(32));
    check("basic_done", LW'(done_drain), LW'(1));
    check("basic_overflow", LW'(overflow), '0);

    // Backpressure: three rows while memory stalls
    restart();
    c_wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b1, i, 1'b0, 0);
    cycle();
    c_wr_ready = 1'b1;
    repeat (6) cycle();
    check("bp_overflow", LW'(overflow), '0);

    // Overflow: six rows into a depth-4 FIFO while stalled
    restart();
    c_wr_ready = 1'b0;
    for (int i = 0; i < 6; i++) drive(1'b1, i, 1'b0, 0);
    check("ovf_set", LW'(overflow), LW'(1));
    n_writes = 0;
    c_wr_ready = 1'b1;
    repeat (10) cycle();
    check("ovf_writes", LW'(n_writes), LW'(5));
    check("ovf_no_done", LW'(done_drain), '0);

    // Full FIFO plus simultaneous accept and push
    restart();
    c_wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) drive(1'b1, i, 1'b0, 0);
    c_wr_ready = 1'b1;
    drive(1'b1, 5, 1'b0, 0);
    check("fullpop_overflow", LW'(overflow), '0);
    repeat (8) cycle();

    // Abort after five writes, then a complete operation
    restart();
    n_writes = 0;
    for (int k = 0; k < 20 && n_writes < 5; k++) drive(1'b1, k, 1'b0, 0);
    start_mat_mul = 1'b0;
    cycle();
    check("abort_wr_en", LW'(c_wr_en), '0);
    start_mat_mul = 1'b1;
    cycle();
    n_writes = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, i, 1'b1, 16 + i);
      drive(1'b0, 0, 1'b0, 0);
    end
    repeat (6) cycle();
    check("restart_writes", LW'(n_writes), LW'(32));
    check("restart_done", LW'(done_drain), LW'(1));

    // Reset in the middle of DRAIN
    restart();
    c_wr_ready = 1'b0;
    drive(1'b1, 0, 1'b0, 0);
    drive(1'b1, 1, 1'b0, 0);
    resetn = 1'b0;
    cycle();
    check("midrst_wr_en", LW'(c_wr_en), '0);
    check("midrst_wr_data", c_wr_data, '0);
    check("midrst_wr_addr", LW'(c_wr_addr), '0);
    check("midrst_overflow", LW'(overflow), '0);
    resetn = 1'b1; start_mat_mul = 1'b0;
    cycle();

    // Address sequence 16,17,19 on lane 1 with stride 1
    start_mat_mul = 1'b1; address_stride_c = SW'(1); c_wr_ready = 1'b1;
    cycle();
    drive(1'b0, 0, 1'b1, 16);
    drive(1'b0, 0, 1'b1, 17);
    drive(1'b0, 0, 1'b1, 19);
    check("addr_seq_error", LW'(addr_error), LW'(chk_en));
    repeat (4) cycle();

    // Randomized traffic
    la0 = 0; la1 = 512; stride = 1;
    for (int n = 0; n < 4000; n++) begin
      resetn = ($urandom_range(0, 999) >= 2);
      if (m_st == 0) begin
        stride = $urandom_range(0, 3);
        address_stride_c = SW'(stride);
        if ($urandom_range(0, 9) == 0) start_mat_mul = 1'b1;
        else start_mat_mul = 1'b0;
      end else if (m_st == 1) begin
        if ($urandom_range(0, 299) == 0) start_mat_mul = 1'b0;
      end else begin
        if ($urandom_range(0, 3) == 0) start_mat_mul = 1'b0;
      end
      c_wr_ready = ($urandom_range(0, 9) < 7);
      c_data_0_available = ($urandom_range(0, 9) < 4);
      c_data_1_available = ($urandom_range(0, 9) < 4);
      c_data_0 = rand_data();
      c_data_1 = rand_data();
      c_addr_0 = AW'(la0 + (($urandom_range(0, 19) == 0) ? 1 : 0));
      c_addr_1 = AW'(la1 + (($urandom_range(0, 19) == 0) ? 1 : 0));
      if (c_data_0_available) la0 = la0 + stride;
      if (c_data_1_available) la1 = la1 + stride;
      cycle();
      c_data_0_available = 1'b0;
      c_data_1_available = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
